// File: rtl/a2d_spi_resp_if.sv
// SPI link between the A2D result responder and its bus master.
interface a2d_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI slave returning stored 12-bit conversion results; a 16-bit command
// frame selects the channel whose value is returned on the following frame.
module a2d_spi_resp (
    input  logic              clk,
    input  logic              rst_n,
    a2d_spi_resp_if.slave     spi,
    input  logic              wr_en,
    input  logic [2:0]        wr_chnnl,
    input  logic [11:0]       wr_data,
    output logic [2:0]        cur_chnnl,
    output logic              cmd_vld,
    output logic              frm_err
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT
    } state_e;

    state_e              state_q, state_d;

    // [0] first sync flop, [1] synchronised value, [2] edge-detect history
    logic [2:0]          ss_q, sclk_q, mosi_q;

    logic [7:0][11:0]    chan_q, chan_d;
    logic [15:0]         tx_shft_q, tx_shft_d;
    // Only command bits [13:11] are ever used, so the upper two bits of the
    // received word are not kept.
    logic [13:0]         rx_shft_q, rx_shft_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          cur_chnnl_q, cur_chnnl_d;

    logic ss_sync, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_bit;
    logic load_tx, rx_en, tx_en, frm_end;

    // Synchronise the asynchronous SPI pins and keep one history sample each
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q   <= '1;
            sclk_q <= '1;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0],   spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[1:0], spi.MOSI};
        end
    end

    assign ss_sync   = ss_q[1];
    assign ss_fall   =  ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] &  ss_q[1];
    assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
    assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
    // MOSI is taken one stage later than SCLK, i.e. the level held just
    // before SCLK rose, which keeps the sample clear of the master's update.
    assign mosi_bit  = mosi_q[2];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: frame opens on SS_n fall, first SCLK rise starts shifting
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall)        state_d = ARMED;
            ARMED:   if (ss_rise)        state_d = IDLE;
                     else if (sclk_rise) state_d = SHIFT;
            SHIFT:   if (ss_rise)        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // FSM outputs: datapath enables and end-of-frame status pulses
    always_comb begin
        load_tx = (state_q == IDLE) && ss_fall;
        rx_en   = (state_q != IDLE) && sclk_rise;
        tx_en   = (state_q == SHIFT) && sclk_fall;
        frm_end = (state_q != IDLE) && ss_rise;
        cmd_vld = frm_end && (bit_cnt_q == 5'd16);
        frm_err = frm_end && (bit_cnt_q != 5'd16);
    end

    // Datapath next-state: channel file, shifters, bit counter, channel latch
    always_comb begin
        chan_d      = chan_q;
        tx_shft_d   = tx_shft_q;
        rx_shft_d   = rx_shft_q;
        bit_cnt_d   = bit_cnt_q;
        cur_chnnl_d = cur_chnnl_q;

        if (wr_en) chan_d[wr_chnnl] = wr_data;

        if (load_tx) begin
            // A write to the selected channel in the same cycle is forwarded
            if (wr_en && (wr_chnnl == cur_chnnl_q))
                tx_shft_d = {4'h0, wr_data};
            else
                tx_shft_d = {4'h0, chan_q[cur_chnnl_q]};
            rx_shft_d = '0;
            bit_cnt_d = '0;
        end else begin
            if (tx_en) tx_shft_d = {tx_shft_q[14:0], 1'b0};
            if (rx_en) begin
                rx_shft_d = {rx_shft_q[12:0], mosi_bit};
                // Saturate so long frames can never wrap back to 16
                if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end

        if (cmd_vld) cur_chnnl_d = rx_shft_q[13:11];
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q      <= '0;
            tx_shft_q   <= '0;
            rx_shft_q   <= '0;
            bit_cnt_q   <= '0;
            cur_chnnl_q <= '0;
        end else begin
            chan_q      <= chan_d;
            tx_shft_q   <= tx_shft_d;
            rx_shft_q   <= rx_shft_d;
            bit_cnt_q   <= bit_cnt_d;
            cur_chnnl_q <= cur_chnnl_d;
        end
    end

    assign cur_chnnl = cur_chnnl_q;
    assign spi.MISO  = ~ss_sync & tx_shft_q[15];

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: directed vector table, random frames
// against a frame-level reference model, and a mid-frame reset sequence.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_chnnl;
    logic [11:0] wr_data;
    logic [2:0]  cur_chnnl;
    logic        cmd_vld;
    logic        frm_err;

    a2d_spi_resp_if spi_if ();

    a2d_spi_resp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi       (spi_if.slave),
        .wr_en     (wr_en),
        .wr_chnnl  (wr_chnnl),
        .wr_data   (wr_data),
        .cur_chnnl (cur_chnnl),
        .cmd_vld   (cmd_vld),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cmd_cnt  = 0;
    int unsigned err_cnt  = 0;

    // Count status pulses away from the active edge
    always @(negedge clk) begin
        if (cmd_vld) cmd_cnt = cmd_cnt + 1;
        if (frm_err) err_cnt = err_cnt + 1;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: channel contents and selected channel at frame level
    logic [11:0] m_chan [8];
    logic [2:0]  m_cur;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_chan[i] = 12'h000;
        m_cur = 3'd0;
    endfunction

    function automatic void model_frame(input logic [15:0] mosi, input int unsigned n,
                                        input logic byp, input logic [2:0] bch,
                                        input logic [11:0] bdat,
                                        output logic [63:0] em, output logic [2:0] ecur,
                                        output int unsigned ecmd, output int unsigned eerr);
        logic [11:0] data;
        logic [63:0] word;
        data = (byp && bch == m_cur) ? bdat : m_chan[m_cur];
        if (byp) m_chan[bch] = bdat;
        word = {52'd0, data};
        if (n <= 16) em = word >> (16 - n);
        else         em = word << (n - 16);
        if (n == 16) begin
            m_cur = mosi[13:11];
            ecmd  = 1;
            eerr  = 0;
        end else begin
            ecmd  = 0;
            eerr  = 1;
        end
        ecur = m_cur;
    endfunction

    task automatic do_write(input logic [2:0] ch, input logic [11:0] dat);
        @(negedge clk);
        wr_en = 1'b1; wr_chnnl = ch; wr_data = dat;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Bus-master frame: MOSI changes on the falling side, MISO sampled on rise
    task automatic do_frame(input logic [15:0] mosi, input int unsigned n,
                            input int unsigned div, input logic cpol,
                            input logic byp, input logic [2:0] bch, input logic [11:0] bdat,
                            output logic [63:0] rx);
        int unsigned half;
        half = div / 2;
        rx = '0;
        @(negedge clk);
        spi_if.SCLK = cpol;
        spi_if.MOSI = 1'b0;
        repeat (4) @(negedge clk);
        spi_if.SS_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (byp) begin
            wr_en = 1'b1; wr_chnnl = bch; wr_data = bdat;
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        for (int unsigned i = 0; i < n; i++) begin
            spi_if.SCLK = 1'b0;
            spi_if.MOSI = (i < 16) ? mosi[15 - i] : 1'b0;
            repeat (half) @(negedge clk);
            spi_if.SCLK = 1'b1;
            rx = {rx[62:0], spi_if.MISO};
            repeat (half) @(negedge clk);
        end
        if (!cpol) begin
            spi_if.SCLK = 1'b0;
            repeat (half) @(negedge clk);
        end
        spi_if.SS_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic        pre_wr;
        logic [2:0]  pre_ch;
        logic [11:0] pre_dat;
        logic        byp;
        logic [2:0]  byp_ch;
        logic [11:0] byp_dat;
        logic [15:0] mosi;
        int unsigned nbits;
        int unsigned div;
        logic        cpol;
        logic [63:0] exp_miso;
        logic [2:0]  exp_cur;
        int unsigned exp_cmd;
        int unsigned exp_err;
    } vec_t;

    vec_t tbl [14];

    task automatic run_and_check(input string tag, input logic [15:0] mosi,
                                 input int unsigned n, input int unsigned div, input logic cpol,
                                 input logic byp, input logic [2:0] bch, input logic [11:0] bdat,
                                 input logic [63:0] em, input logic [2:0] ecur,
                                 input int unsigned ecmd, input int unsigned eerr);
        int unsigned c0, e0;
        logic [63:0] rx;
        c0 = cmd_cnt;
        e0 = err_cnt;
        do_frame(mosi, n, div, cpol, byp, bch, bdat, rx);
        chk({tag, " miso"},    rx, em);
        chk({tag, " cur"},     64'(cur_chnnl), 64'(ecur));
        chk({tag, " cmd_vld"}, 64'(cmd_cnt - c0), 64'(ecmd));
        chk({tag, " frm_err"}, 64'(err_cnt - e0), 64'(eerr));
    endtask

    initial begin
        vec_t        v;
        logic [63:0] em;
        logic [2:0]  ecur;
        int unsigned ecmd, eerr, c0, e0;

        tbl[0]  = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h0000, 16,  8, 1'b0, 64'h0000, 3'd0, 1, 0};
        tbl[1]  = '{1'b1, 3'd5, 12'hA5C, 1'b0, 3'd0, 12'h000, 16'h2800, 16,  8, 1'b0, 64'h0000, 3'd5, 1, 0};
        tbl[2]  = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h0000, 16,  8, 1'b1, 64'h0A5C, 3'd0, 1, 0};
        tbl[3]  = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h2800, 16, 32, 1'b0, 64'h0000, 3'd5, 1, 0};
        tbl[4]  = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h2800, 16, 32, 1'b1, 64'h0A5C, 3'd5, 1, 0};
        tbl[5]  = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h3800, 10,  8, 1'b0, 64'h0029, 3'd5, 0, 1};
        tbl[6]  = '{1'b1, 3'd3, 12'h123, 1'b0, 3'd0, 12'h000, 16'h1800, 16, 16, 1'b1, 64'h0A5C, 3'd3, 1, 0};
        tbl[7]  = '{1'b0, 3'd0, 12'h000, 1'b1, 3'd3, 12'hFFF, 16'h0000, 16,  8, 1'b0, 64'h0FFF, 3'd0, 1, 0};
        tbl[8]  = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h1800, 16,  8, 1'b1, 64'h0000, 3'd3, 1, 0};
        tbl[9]  = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h0000, 16, 16, 1'b0, 64'h0FFF, 3'd0, 1, 0};
        tbl[10] = '{1'b0, 3'd0, 12'h000, 1'b1, 3'd6, 12'h777, 16'h3000, 16,  8, 1'b0, 64'h0000, 3'd6, 1, 0};
        tbl[11] = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'hC7FF, 16,  8, 1'b1, 64'h0777, 3'd0, 1, 0};
        tbl[12] = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h1800, 16,  8, 1'b0, 64'h0000, 3'd3, 1, 0};
        tbl[13] = '{1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000, 16'h2800, 48,  8, 1'b1,
                    64'h0000_0FFF_0000_0000, 3'd3, 0, 1};

        rst_n = 1'b0;
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b0;
        spi_if.MOSI = 1'b0;
        wr_en = 1'b0; wr_chnnl = 3'd0; wr_data = 12'h000;
        model_reset();
        #1;
        chk("reset MISO",    64'(spi_if.MISO), 64'd0);
        chk("reset cur",     64'(cur_chnnl),   64'd0);
        chk("reset cmd_vld", 64'(cmd_vld),     64'd0);
        chk("reset frm_err", 64'(frm_err),     64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            v = tbl[i];
            if (v.pre_wr) begin
                do_write(v.pre_ch, v.pre_dat);
                m_chan[v.pre_ch] = v.pre_dat;
            end
            model_frame(v.mosi, v.nbits, v.byp, v.byp_ch, v.byp_dat, em, ecur, ecmd, eerr);
            run_and_check($sformatf("vec%0d", i), v.mosi, v.nbits, v.div, v.cpol,
                          v.byp, v.byp_ch, v.byp_dat, v.exp_miso, v.exp_cur,
                          v.exp_cmd, v.exp_err);
        end

        // Random frames against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [15:0] mosi;
            int unsigned n, div;
            logic        cpol, byp;
            logic [2:0]  bch;
            logic [11:0] bdat;
            if ($urandom_range(0, 1) == 1) begin
                bch  = 3'($urandom_range(0, 7));
                bdat = 12'($urandom);
                do_write(bch, bdat);
                m_chan[bch] = bdat;
            end
            mosi = 16'($urandom);
            n    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 24) : 16;
            div  = ($urandom_range(0, 3) == 0) ? 32 : (($urandom_range(0, 1) == 1) ? 16 : 8);
            cpol = 1'($urandom_range(0, 1));
            byp  = ($urandom_range(0, 3) == 0);
            bch  = ($urandom_range(0, 1) == 1) ? m_cur : 3'($urandom_range(0, 7));
            bdat = 12'($urandom);
            model_frame(mosi, n, byp, bch, bdat, em, ecur, ecmd, eerr);
            run_and_check($sformatf("rnd%0d", i), mosi, n, div, cpol, byp, bch, bdat,
                          em, ecur, ecmd, eerr);
        end

        // Reset in the middle of a frame aborts it silently
        do_write(3'd2, 12'hABC);
        m_chan[2] = 12'hABC;
        model_frame(16'h3800, 16, 1'b0, 3'd0, 12'h000, em, ecur, ecmd, eerr);
        run_and_check("pre_abort", 16'h3800, 16, 8, 1'b0, 1'b0, 3'd0, 12'h000,
                      em, ecur, ecmd, eerr);
        @(negedge clk);
        spi_if.SCLK = 1'b0;
        repeat (4) @(negedge clk);
        spi_if.SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            spi_if.SCLK = 1'b0;
            spi_if.MOSI = 1'($urandom_range(0, 1));
            repeat (4) @(negedge clk);
            spi_if.SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        c0 = cmd_cnt;
        e0 = err_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("abort MISO",    64'(spi_if.MISO), 64'd0);
        chk("abort cur",     64'(cur_chnnl),   64'd0);
        chk("abort cmd_vld", 64'(cmd_vld),     64'd0);
        chk("abort frm_err", 64'(frm_err),     64'd0);
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort cmd pulses", 64'(cmd_cnt - c0), 64'd0);
        chk("abort err pulses", 64'(err_cnt - e0), 64'd0);
        model_reset();
        model_frame(16'h1000, 16, 1'b0, 3'd0, 12'h000, em, ecur, ecmd, eerr);
        run_and_check("post_abort0", 16'h1000, 16, 8, 1'b0, 1'b0, 3'd0, 12'h000,
                      64'h0000, 3'd2, 1, 0);
        model_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, em, ecur, ecmd, eerr);
        run_and_check("post_abort1", 16'h0000, 16, 8, 1'b1, 1'b0, 3'd0, 12'h000,
                      64'h0000, 3'd0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/a2d_spi_resp.md
A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

Interface
REQ-001 clk  input  1  system clock; SPI inputs are oversampled in this domain (clk >= 8x SCLK).
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SS_n  input  1  SPI slave select from the master, active-low, asynchronous to clk.
REQ-004 SCLK  input  1  SPI serial clock from the master, asynchronous to clk.
REQ-005 MOSI  input  1  SPI serial data from the master, asynchronous to clk.
REQ-006 MISO  output  1  serial result data to the master.
REQ-007 wr_en  input  1  single-cycle strobe that writes wr_data into channel register wr_chnnl.
REQ-008 wr_chnnl  input  3  channel index for the write port.
REQ-009 wr_data  input  12  conversion value for the write port.
REQ-010 cur_chnnl  output  3  channel latched from the last valid command frame.
REQ-011 cmd_vld  output  1  one-clk pulse: a valid 16-bit command frame has completed.
REQ-012 frm_err  output  1  one-clk pulse: a frame ended with a bit count other than 16.

Function
REQ-013 Synchronisation: SS_n, SCLK and MOSI SHALL each pass through a 2-flop synchroniser plus one history flop for edge detection.
  - SS_n, SCLK synchroniser flops reset to 1.
  - MOSI synchroniser flops reset to 0.
REQ-014 Edge detects SHALL be single-cycle pulses: ss_fall, ss_rise, sclk_rise, sclk_fall.
REQ-015 Channel storage: eight 12-bit registers, all reset to 0x000.
  - A wr_en write SHALL update the selected register on the next clk edge.
REQ-016 FSM states SHALL be IDLE, ARMED and SHIFT; reset state IDLE.
REQ-017 IDLE->ARMED on ss_fall. The same cycle SHALL:
  - load tx_shft[15:0] = {4'h0, chan[cur_chnnl]};
  - clear rx_shft and bit_cnt.
REQ-018 Write bypass: if wr_en is high with wr_chnnl==cur_chnnl in the ss_fall cycle, tx_shft SHALL load wr_data.
REQ-019 ARMED->SHIFT on the first sclk_rise. In ARMED, sclk_fall SHALL be ignored, so any SCLK idle polarity works.
REQ-020 Rising-edge behaviour in ARMED and SHIFT, on every sclk_rise:
  - rx_shft <= {rx_shft[14:0], MOSI_sync};
  - bit_cnt increments and saturates at 31.
REQ-021 Falling-edge behaviour in SHIFT, on every sclk_fall: tx_shft <= {tx_shft[14:0], 1'b0}.
REQ-022 MISO SHALL equal tx_shft[15] while SS_n_sync is low, and 0 while SS_n_sync is high.
REQ-023 On ss_rise (ARMED or SHIFT -> IDLE) with bit_cnt==16:
  - cur_chnnl <= rx_shft[13:11];
  - cmd_vld pulses for 1 clk.
REQ-024 On ss_rise with bit_cnt!=16:
  - frm_err pulses for 1 clk;
  - cur_chnnl is unchanged and cmd_vld stays 0.
REQ-025 Command rx_shft[15:14] and [10:0] SHALL be ignored.
REQ-026 Result pipeline: each frame returns data for the channel latched by the previous valid frame.
  - A 2-frame master sequence (command, then read) yields chan[N] on the second frame.
REQ-027 Bit order SHALL be MSB first on both MOSI and MISO.
REQ-028 A ss_fall seen outside IDLE is impossible. A glitch SS_n high->low within 1 clk SHALL be treated as ss_rise then ss_fall, processed in order.

Reset
REQ-029 rst_n low SHALL asynchronously force:
  - FSM=IDLE, MISO=0, cur_chnnl=0, cmd_vld=0, frm_err=0;
  - all shift registers, bit_cnt and channel registers to 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no cmd_vld or frm_err. After release, the next frame SHALL start cleanly at its ss_fall.

Verification
REQ-031 Write ch5=0xA5C; frame 1 MOSI=0x2800 (ch5); frame 2 any MOSI -> frame-2 MISO=0x0A5C, cur_chnnl=5, cmd_vld pulses once per frame.
REQ-032 After reset, first frame -> MISO=0x0000 (ch0 reset value), cur_chnnl=0.
REQ-033 Frame of 10 SCLKs carrying 0x3800 -> frm_err one pulse, no cmd_vld, cur_chnnl unchanged.
REQ-034 cur_chnnl=3; wr_en ch3=0xFFF in the ss_fall cycle -> MISO returns 0x0FFF.
REQ-035 Run with SCLK idle-high and idle-low masters at clk/8 and clk/32 -> identical rx/tx data.
REQ-036 rst_n pulsed after 7 SCLKs of a frame -> outputs at reset values; next full frame 0x1000 -> cur_chnnl=2.
